mem_bist_ctrl: RTL and testbench



---
 rtl/mem_bist_pkg.sv | 40 ++++
 rtl/mem_bist_if.sv | 35 +++
 rtl/mem_bist_lfsr.sv | 36 +++
 rtl/mem_bist_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// ============================================================================
// Module : mem_bist_pkg
// Brief  : Shared types and constants for the 32x8 memory self-test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_bist_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

    // Galois taps for x^8+x^6+x^5+x^4+1, right-shifting form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] RAND_MIN  = 8'h20;
    localparam logic [7:0] RAND_MAX  = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PH_CLR  = 2'd0,
        PH_ADDR = 2'd1,
        PH_RAND = 2'd2
    } phase_e;

    // Random-phase pattern: 7 LFSR bits, lifted into 0x20..0x7F
    function automatic logic [7:0] rand_data(input logic [7:0] lfsr);
        return (lfsr & RAND_MAX) | ((lfsr[6:5] == 2'b00) ? RAND_MIN : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bist_if.sv
// ============================================================================
// Module : mem_bist_if
// Brief  : Synchronous memory port driven by the self-test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_bist_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bist_lfsr.sv
// ============================================================================
// Module : mem_bist_lfsr
// Brief  : 8-bit Galois LFSR for the random phase; exists only when
//          MEM_BIST_RAND_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef MEM_BIST_RAND_EN
module mem_bist_lfsr
    import mem_bist_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [7:0] seed,
    input  wire logic       load,
    input  wire logic       adv,
    output logic      [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= seed;
        end else if (adv) begin
            value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
// ============================================================================
// Module : mem_bist_ctrl
// Brief  : Memory self-test sequencer: CLR, ADDR and (with MEM_BIST_RAND_EN)
//          RAND phases, saturating miscompare count and first-fail address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int         ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int         DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int         ERR_WIDTH  = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic      [ERR_WIDTH-1:0]  err_count,
    output logic      [ADDR_WIDTH-1:0] fail_addr,
    mem_bist_if.master                 mem
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

    state_e                r_state;
    state_e                w_state_next;
    phase_e                r_phase;
    phase_e                w_phase_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_last;
    logic                  w_clear_run;
    logic                  w_miscompare;
    logic [DATA_WIDTH-1:0] w_expected;

`ifdef MEM_BIST_RAND_EN
    logic       w_lfsr_adv;
    logic [7:0] w_lfsr_value;

    mem_bist_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .load  (w_clear_run),
        .adv   (w_lfsr_adv),
        .value (w_lfsr_value)
    );
`endif

    assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
    assign w_last     = (r_addr == LAST_ADDR);

    // Pattern for the current phase/address; drives writes and CHECK alike
    always_comb begin
        w_expected = '0;
        case (r_phase)
            PH_ADDR: w_expected = DATA_WIDTH'(r_addr);
`ifdef MEM_BIST_RAND_EN
            PH_RAND: w_expected = DATA_WIDTH'(rand_data(w_lfsr_value));
`endif
            default: w_expected = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= PH_CLR;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_addr  <= w_addr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_addr_next  = r_addr;
        w_clear_run  = 1'b0;
`ifdef MEM_BIST_RAND_EN
        w_lfsr_adv   = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_WRITE;
                    w_phase_next = PH_CLR;
                    w_addr_next  = '0;
                    w_clear_run  = 1'b1;
                end
            end
            ST_WRITE: begin
`ifdef MEM_BIST_RAND_EN
                if (r_phase == PH_RAND) begin
                    w_state_next = ST_READ;
                end else
`endif
                if (w_last) begin
                    w_state_next = ST_READ;
                    w_addr_next  = '0;
                end else begin
                    w_addr_next  = w_addr_inc;
                end
            end
            ST_READ: begin
                w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
`ifdef MEM_BIST_RAND_EN
                if (r_phase == PH_RAND) begin
                    w_lfsr_adv = 1'b1;
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_WRITE;
                        w_addr_next  = w_addr_inc;
                    end
                end else
`endif
                if (!w_last) begin
                    w_state_next = ST_READ;
                    w_addr_next  = w_addr_inc;
                end else if (r_phase == PH_CLR) begin
                    w_state_next = ST_WRITE;
                    w_phase_next = PH_ADDR;
                    w_addr_next  = '0;
                end else begin
`ifdef MEM_BIST_RAND_EN
                    w_state_next = ST_WRITE;
                    w_phase_next = PH_RAND;
                    w_addr_next  = '0;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_miscompare = (r_state == ST_CHECK) && (mem.mem_rdata != w_expected);

    // A zero count means no miscompare yet this run, so it gates the first-fail capture
    always_ff @(posedge clk) begin
        if (reset || w_clear_run) begin
            err_count <= '0;
            fail_addr <= '0;
        end else if (w_miscompare) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + ERR_WIDTH'(1);
            end
            if (err_count == '0) begin
                fail_addr <= r_addr;
            end
        end
    end

    assign busy          = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_CHECK);
    assign done          = (r_state == ST_DONE);
    assign pass          = done && (err_count == '0);
    assign mem.mem_write = (r_state == ST_WRITE);
    assign mem.mem_read  = (r_state == ST_READ);
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = w_expected;

endmodule

`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
// ============================================================================
// Module : tb_mem_bist_ctrl
// Brief  : Self-checking bench for mem_bist_ctrl with a fault-injecting memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_bist_ctrl;

    localparam int ERR_W   = 6;
    localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef MEM_BIST_RAND_EN
    localparam int NPH     = 3;
`else
    localparam int NPH     = 2;
`endif
    localparam int RUN_LEN = NPH * 96;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int mode; int exp_err; int exp_fail; int exp_pass; } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_count;
    logic [4:0]       fail_addr;

    mem_bist_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) mem_if ();

    mem_bist_ctrl #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (8),
        .ERR_WIDTH  (ERR_W),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    int   start_edge = 0;
    int   mode = 0;
    bit   both_seen = 1'b0;
    wr_t  exp_q[$];
    logic [7:0] mem_arr [0:31];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fault(input int m, input int a, input logic [7:0] d);
        case (m)
            1:       return (a == 5) ? (d | 8'h08) : d;
            2:       return (a == 7) ? 8'hFF : d;
            3:       return 8'hFF;
            default: return d;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        logic [7:0] s;
        s = {1'b0, l[7:1]};
        if (l[0]) s = s ^ 8'hB8;
        return s;
    endfunction

    function automatic logic [7:0] pattern(input int ph, input int a, input logic [7:0] l);
        logic [7:0] d;
        if (ph == 0) d = 8'h00;
        else if (ph == 1) d = 8'(a);
        else begin
            d = {1'b0, l[6:0]};
            if (l[6:5] == 2'b00) d = d | 8'h20;
        end
        return d;
    endfunction

    // Expected error count and first failing address for a fault mode
    task automatic model(input int m, output int err, output int fa);
        logic [7:0] l = 8'hA5;
        logic [7:0] d;
        int cnt = 0;
        fa = 0;
        for (int ph = 0; ph < NPH; ph++) begin
            for (int a = 0; a < 32; a++) begin
                d = pattern(ph, a, l);
                if (fault(m, a, d) != d) begin
                    if (cnt == 0) fa = a;
                    cnt++;
                end
                if (ph == 2) l = lfsr_next(l);
            end
        end
        err = (cnt > ERR_MAX) ? ERR_MAX : cnt;
    endtask

    task automatic build_exp();
        logic [7:0] l = 8'hA5;
        exp_q.delete();
        for (int ph = 0; ph < NPH; ph++) begin
            for (int a = 0; a < 32; a++) begin
                exp_q.push_back('{addr: a, data: int'(pattern(ph, a, l))});
                if (ph == 2) l = lfsr_next(l);
            end
        end
    endtask

    // Memory model with fault injection on the read path
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (mem_if.mem_write) mem_arr[mem_if.mem_addr] <= mem_if.mem_wdata;
        if (mem_if.mem_read)
            mem_if.mem_rdata <= fault(mode, int'(mem_if.mem_addr), mem_arr[mem_if.mem_addr]);
    end

    // Scoreboard: every write strobe pops the next expected (addr, data)
    always @(negedge clk) begin
        if (mem_if.mem_read && mem_if.mem_write) both_seen = 1'b1;
        if (mem_if.mem_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_if.mem_addr, e.addr);
                check("wr_data", mem_if.mem_wdata, e.data);
            end
        end
    end

    task automatic start_run(input int m);
        mode = m;
        build_exp();
        both_seen = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start_edge = edge_cnt;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < RUN_LEN + 50; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        check("done_seen", done, 1);
        check("latency", edge_cnt - start_edge, RUN_LEN);
        check("busy_at_done", busy, 0);
        check("strobes_at_done", {mem_if.mem_read, mem_if.mem_write}, 0);
        check("writes_left", exp_q.size(), 0);
        check("rd_wr_overlap", both_seen, 0);
    endtask

    vec_t tbl[4];

    initial begin
        int e, f;
        for (int i = 0; i < 4; i++) begin
            model(i, e, f);
            tbl[i] = '{mode: i, exp_err: e, exp_fail: f, exp_pass: (e == 0) ? 1 : 0};
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_strobes", {mem_if.mem_read, mem_if.mem_write}, 0);
        check("rst_addr", mem_if.mem_addr, 0);
        check("rst_wdata", mem_if.mem_wdata, 0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            start_run(tbl[i].mode);
            wait_done();
            check("err_count", err_count, tbl[i].exp_err);
            check("fail_addr", fail_addr, tbl[i].exp_fail);
            check("pass", pass, tbl[i].exp_pass);
            repeat (3) @(posedge clk);
            #1 check("done_held", done, 1);
        end

        // start re-pulsed mid-run must not restart the test
        start_run(0);
        while (edge_cnt - start_edge < 49) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();
        check("repulse_pass", pass, 1);

        // reset mid-run aborts on that edge
        start_run(3);
        while (edge_cnt - start_edge < 99) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_write", mem_if.mem_write, 0);
        check("abort_done", done, 0);
        check("abort_err", err_count, 0);
        @(negedge clk) reset = 1'b0;
        exp_q.delete();
        start_run(0);
        wait_done();
        check("rerun_pass", pass, 1);
        check("rerun_err", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
